// File: rtl/issue_queue_if.sv
// Fetch-side push port, stall/flush controls and lane outputs of the issue queue.
interface issue_queue_if #(
  parameter int LANES = 2,
  parameter int DEPTH = 8,
  parameter int IR_W  = 16,
  parameter int PC_W  = 8,
  parameter int NREG  = 8
);
  localparam int RW    = $clog2(NREG);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                    push_valid;
  logic                    push_ready;
  logic [IR_W-1:0]         push_ir;
  logic [PC_W-1:0]         push_pc;
  logic                    push_write;
  logic [RW-1:0]           push_wnum;
  logic [NREG-1:0]         push_rmask;
  logic                    push_load;
  logic                    hold;
  logic                    flush;
  logic [LANES-1:0]        out_valid;
  logic [LANES*IR_W-1:0]   out_ir;
  logic [LANES*PC_W-1:0]   out_pc;
  logic [CNT_W-1:0]        count;

  modport master (
    output push_valid, push_ir, push_pc, push_write, push_wnum, push_rmask, push_load,
    output hold, flush,
    input  push_ready, out_valid, out_ir, out_pc, count
  );

  modport slave (
    input  push_valid, push_ir, push_pc, push_write, push_wnum, push_rmask, push_load,
    input  hold, flush,
    output push_ready, out_valid, out_ir, out_pc, count
  );
endinterface

// File: rtl/issue_queue.sv
// In-order circular instruction buffer issuing up to LANES dependency-free entries per cycle.
// Optional load-use interlock enabled by defining ISSUE_LOAD_USE_EN.
module issue_queue #(
  parameter int LANES = 2,
  parameter int DEPTH = 8,
  parameter int IR_W  = 16,
  parameter int PC_W  = 8,
  parameter int NREG  = 8
) (
  input logic          clk,
  input logic          rst,
  issue_queue_if.slave bus
);
  localparam int RW    = $clog2(NREG);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [IR_W-1:0]       mem_ir    [DEPTH];
  logic [PC_W-1:0]       mem_pc    [DEPTH];
  logic                  mem_write [DEPTH];
  logic [RW-1:0]         mem_wnum  [DEPTH];
  logic [NREG-1:0]       mem_rmask [DEPTH];

  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;
  logic [LANES-1:0]      lane_valid;
  logic [LANES*IR_W-1:0] lane_ir;
  logic [LANES*PC_W-1:0] lane_pc;

  logic                  push_fire;
  logic [PTR_W-1:0]      idx      [LANES];
  logic                  conflict [LANES];
  logic [LANES-1:0]      elig;
  logic [CNT_W-1:0]      k;
  logic                  ld_block;

  assign bus.push_ready = (count != CNT_W'(DEPTH)) && !bus.flush && !rst;
  assign push_fire      = bus.push_valid && bus.push_ready;
  assign bus.count      = count;
  assign bus.out_valid  = lane_valid;
  assign bus.out_ir     = lane_ir;
  assign bus.out_pc     = lane_pc;

`ifdef ISSUE_LOAD_USE_EN
  logic [NREG-1:0] ld_mask;
  logic [NREG-1:0] issued_ld;
  logic            mem_load [DEPTH];

  assign ld_block = |(mem_rmask[head] & ld_mask);

  // Destination mask of loads leaving in the current bundle.
  always_comb begin
    issued_ld = {NREG{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      issued_ld = issued_ld
                | ({NREG{elig[i] && mem_load[idx[i]] && mem_write[idx[i]]}}
                   & (NREG'(1'b1) << mem_wnum[idx[i]]));
    end
  end

  // Load-use tracking register; frozen while downstream holds.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      ld_mask <= {NREG{1'b0}};
    end else if (!bus.hold) begin
      ld_mask <= issued_ld;
    end else begin
      ld_mask <= ld_mask;
    end
  end

  // Load flag storage alongside the other entry fields.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem_load[tail] <= bus.push_load;
    end
  end
`else
  logic unused_load;
  assign unused_load = bus.push_load;
  assign ld_block    = 1'b0;
`endif

  // Bundle selection: eligibility is a prefix, cut at the first intra-bundle hazard.
  always_comb begin
    elig = {LANES{1'b0}};
    k    = {CNT_W{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      idx[i]      = head + PTR_W'(i);
      conflict[i] = 1'b0;
    end
    for (int i = 0; i < LANES; i++) begin
      for (int j = 0; j < i; j++) begin
        conflict[i] = conflict[i]
                    | (mem_write[idx[j]]
                       && (mem_rmask[idx[i]][mem_wnum[idx[j]]]
                           || (mem_write[idx[i]] && (mem_wnum[idx[i]] == mem_wnum[idx[j]]))));
      end
      if (i == 0) begin
        elig[i] = (count != {CNT_W{1'b0}}) && !bus.hold && !ld_block;
      end else begin
        elig[i] = elig[i-1] && (CNT_W'(i) < count) && !conflict[i];
      end
      k = k + CNT_W'(elig[i]);
    end
  end

  // Entry storage; written only on an accepted push, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem_ir[tail]    <= bus.push_ir;
      mem_pc[tail]    <= bus.push_pc;
      mem_write[tail] <= bus.push_write;
      mem_wnum[tail]  <= bus.push_wnum;
      mem_rmask[tail] <= bus.push_rmask;
    end
  end

  // Pointers, occupancy and the issue register.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      head       <= {PTR_W{1'b0}};
      tail       <= {PTR_W{1'b0}};
      count      <= {CNT_W{1'b0}};
      lane_valid <= {LANES{1'b0}};
      lane_ir    <= {(LANES*IR_W){1'b0}};
      lane_pc    <= {(LANES*PC_W){1'b0}};
    end else begin
      if (push_fire) begin
        tail <= tail + PTR_W'(1);
      end
      // k is zero under hold, so head/count only move when issuing.
      head  <= head + PTR_W'(k);
      count <= count + CNT_W'(push_fire) - k;
      if (!bus.hold) begin
        for (int i = 0; i < LANES; i++) begin
          lane_valid[i]            <= elig[i];
          lane_ir[i*IR_W +: IR_W] <= elig[i] ? mem_ir[idx[i]] : {IR_W{1'b0}};
          lane_pc[i*PC_W +: PC_W] <= elig[i] ? mem_pc[idx[i]] : {PC_W{1'b0}};
        end
      end
    end
  end
endmodule

// File: tb/tb_issue_queue.sv
// Directed table-driven bench for issue_queue (LANES=2, DEPTH=8) plus wrap and reset sequences.
module tb_issue_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  issue_queue_if bus ();
  issue_queue dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic       pv;
    logic [7:0] pc;
    logic       wr;
    logic [2:0] wn;
    logic [7:0] rm;
    logic       ld;
    logic       hold;
    logic       flush;
    logic [1:0] ev;
    logic [7:0] epc0;
    logic [7:0] epc1;
    logic [3:0] ecnt;
  } vec_t;

  vec_t vt[$];

  function automatic logic [15:0] irof(input logic [7:0] pc);
    return {pc ^ 8'hA5, pc};
  endfunction

  task automatic add(input logic pv, input logic [7:0] pc, input logic wr, input logic [2:0] wn,
                     input logic [7:0] rm, input logic ld, input logic hold, input logic flush,
                     input logic [1:0] ev, input logic [7:0] epc0, input logic [7:0] epc1,
                     input logic [3:0] ecnt);
    vec_t v;
    v.pv = pv; v.pc = pc; v.wr = wr; v.wn = wn; v.rm = rm; v.ld = ld;
    v.hold = hold; v.flush = flush; v.ev = ev; v.epc0 = epc0; v.epc1 = epc1; v.ecnt = ecnt;
    vt.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [7:0] pc, input logic wr, input logic [2:0] wn,
                       input logic [7:0] rm, input logic ld, input logic hold, input logic flush);
    bus.push_valid = pv;
    bus.push_pc    = pc;
    bus.push_ir    = irof(pc);
    bus.push_write = wr;
    bus.push_wnum  = wn;
    bus.push_rmask = rm;
    bus.push_load  = ld;
    bus.hold       = hold;
    bus.flush      = flush;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_pc;
    int next_pc;
    logic pv;

    // Independent pair issued together
    add(1'b1, 8'd1, 1'b1, 3'd1, 8'h00, 1'b0, 1'b1, 1'b0, 2'b00, 8'd0, 8'd0, 4'd1);
    add(1'b1, 8'd2, 1'b1, 3'd2, 8'h08, 1'b0, 1'b1, 1'b0, 2'b00, 8'd0, 8'd0, 4'd2);
    add(1'b0, 8'd0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b11, 8'd1, 8'd2, 4'd0);
    // RAW split (pushes under hold keep the previous bundle frozen)
    add(1'b1, 8'd3, 1'b1, 3'd1, 8'h00, 1'b0, 1'b1, 1'b0, 2'b11, 8'd1, 8'd2, 4'd1);
    add(1'b1, 8'd4, 1'b1, 3'd3, 8'h02, 1'b0, 1'b1, 1'b0, 2'b11, 8'd1, 8'd2, 4'd2);
    add(1'b0, 8'd0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b01, 8'd3, 8'd0, 4'd1);
    add(1'b0, 8'd0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b01, 8'd4, 8'd0, 4'd0);
    add(1'b0, 8'd0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0, 8'd0, 4'd0);
    // Load-use: load A writes r4, B reads r4, C independent
    add(1'b1, 8'd5, 1'b1, 3'd4, 8'h00, 1'b1, 1'b1, 1'b0, 2'b00, 8'd0, 8'd0, 4'd1);
    add(1'b1, 8'd6, 1'b1, 3'd5, 8'h10, 1'b0, 1'b1, 1'b0, 2'b00, 8'd0, 8'd0, 4'd2);
    add(1'b1, 8'd7, 1'b1, 3'd6, 8'h01, 1'b0, 1'b1, 1'b0, 2'b00, 8'd0, 8'd0, 4'd3);
    add(1'b0, 8'd0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b01, 8'd5, 8'd0, 4'd2);
`ifdef ISSUE_LOAD_USE_EN
    add(1'b0, 8'd0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0, 8'd0, 4'd2);
    add(1'b0, 8'd0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b11, 8'd6, 8'd7, 4'd0);
`else
    add(1'b0, 8'd0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b11, 8'd6, 8'd7, 4'd0);
    add(1'b0, 8'd0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0, 8'd0, 4'd0);
`endif
    add(1'b0, 8'd0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0, 8'd0, 4'd0);
    // WAW split
    add(1'b1, 8'd8, 1'b1, 3'd2, 8'h00, 1'b0, 1'b1, 1'b0, 2'b00, 8'd0, 8'd0, 4'd1);
    add(1'b1, 8'd9, 1'b1, 3'd2, 8'h00, 1'b0, 1'b1, 1'b0, 2'b00, 8'd0, 8'd0, 4'd2);
    add(1'b0, 8'd0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b01, 8'd8, 8'd0, 4'd1);
    add(1'b0, 8'd0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b01, 8'd9, 8'd0, 4'd0);
    // Hold for 3 cycles while a full bundle is on the lanes
    add(1'b1, 8'd10, 1'b1, 3'd1, 8'h00, 1'b0, 1'b1, 1'b0, 2'b01, 8'd9, 8'd0, 4'd1);
    add(1'b1, 8'd11, 1'b1, 3'd2, 8'h00, 1'b0, 1'b1, 1'b0, 2'b01, 8'd9, 8'd0, 4'd2);
    add(1'b1, 8'd12, 1'b1, 3'd3, 8'h00, 1'b0, 1'b0, 1'b0, 2'b11, 8'd10, 8'd11, 4'd1);
    add(1'b1, 8'd13, 1'b1, 3'd4, 8'h00, 1'b0, 1'b1, 1'b0, 2'b11, 8'd10, 8'd11, 4'd2);
    add(1'b1, 8'd14, 1'b1, 3'd5, 8'h00, 1'b0, 1'b1, 1'b0, 2'b11, 8'd10, 8'd11, 4'd3);
    add(1'b0, 8'd0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 2'b11, 8'd10, 8'd11, 4'd3);
    add(1'b0, 8'd0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b11, 8'd12, 8'd13, 4'd1);
    add(1'b0, 8'd0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b01, 8'd14, 8'd0, 4'd0);
    // Flush with a simultaneous push at count 5
    for (int i = 0; i < 5; i++) begin
      add(1'b1, 8'(15 + i), 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 2'b01, 8'd14, 8'd0, 4'(i + 1));
    end
    add(1'b1, 8'd20, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b1, 2'b00, 8'd0, 8'd0, 4'd0);
    add(1'b0, 8'd0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0, 8'd0, 4'd0);

    // Reset state
    drive(1'b0, 8'd0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    step();
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset out_pc", 32'(bus.out_pc), 32'd0);
    check("reset count", 32'(bus.count), 32'd0);
    check("reset push_ready", 32'(bus.push_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("post-reset push_ready", 32'(bus.push_ready), 32'd1);

    for (int r = 0; r < vt.size(); r++) begin
      drive(vt[r].pv, vt[r].pc, vt[r].wr, vt[r].wn, vt[r].rm, vt[r].ld, vt[r].hold, vt[r].flush);
      step();
      check($sformatf("row%0d out_valid", r), 32'(bus.out_valid), 32'(vt[r].ev));
      check($sformatf("row%0d pc0", r), 32'(bus.out_pc[7:0]), 32'(vt[r].epc0));
      check($sformatf("row%0d pc1", r), 32'(bus.out_pc[15:8]), 32'(vt[r].epc1));
      check($sformatf("row%0d ir0", r), 32'(bus.out_ir[15:0]),
            vt[r].ev[0] ? 32'(irof(vt[r].epc0)) : 32'd0);
      check($sformatf("row%0d ir1", r), 32'(bus.out_ir[31:16]),
            vt[r].ev[1] ? 32'(irof(vt[r].epc1)) : 32'd0);
      check($sformatf("row%0d count", r), 32'(bus.count), 32'(vt[r].ecnt));
      check($sformatf("row%0d push_ready", r), 32'(bus.push_ready),
            32'((vt[r].ecnt != 4'd8) && !vt[r].flush));
    end

    // Fill to DEPTH under hold, then drain 28 entries through wrapping pointers
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'(100 + i), 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0);
      step();
      check($sformatf("fill%0d count", i), 32'(bus.count), 32'(i + 1));
    end
    check("full push_ready", 32'(bus.push_ready), 32'd0);
    check("full out_valid", 32'(bus.out_valid), 32'd0);
    exp_pc  = 100;
    next_pc = 108;
    for (int cyc = 0; cyc < 200 && exp_pc < 128; cyc++) begin
      pv = bus.push_ready && (next_pc < 128);
      drive(pv, 8'(next_pc), 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
      if (pv) next_pc++;
      step();
      if (cyc == 0) check("full-pop count", 32'(bus.count), 32'd6);
      check($sformatf("wrap%0d count bound", cyc), 32'(bus.count <= 4'd8), 32'd1);
      for (int l = 0; l < 2; l++) begin
        if (bus.out_valid[l]) begin
          check($sformatf("wrap pc lane%0d", l), 32'(bus.out_pc[l*8 +: 8]), 32'(exp_pc));
          check($sformatf("wrap ir lane%0d", l), 32'(bus.out_ir[l*16 +: 16]),
                32'(irof(8'(exp_pc))));
          exp_pc++;
        end
      end
    end
    check("wrap drained all", 32'(exp_pc), 32'd128);
    drive(1'b0, 8'd0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    check("wrap final count", 32'(bus.count), 32'd0);

    // Reset mid-operation with a simultaneous push
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'(200 + i), 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0);
      step();
    end
    check("pre-rst count", 32'(bus.count), 32'd5);
    drive(1'b1, 8'd205, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    check("rst count", 32'(bus.count), 32'd0);
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst out_pc", 32'(bus.out_pc), 32'd0);
    check("rst out_ir", 32'(bus.out_ir), 32'd0);
    check("rst push_ready", 32'(bus.push_ready), 32'd0);
    rst = 1'b0;
    drive(1'b0, 8'd0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    check("post-rst count", 32'(bus.count), 32'd0);
    check("post-rst out_valid", 32'(bus.out_valid), 32'd0);
    check("post-rst push_ready", 32'(bus.push_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
